load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit replacing the fixed-latency memory stage: accepts one memory instruction per handshake, drives a variable-latency data-memory port with byte enables, aligns and extends load data, flags misaligned accesses, and buffers results for write-back in a small response FIFO. Sits between the execute stage (operands, `instruction_type`) and the register-bank write-back.

## Interface
- `DEPTH`, 2: response FIFO entries (≥1); also the in-flight + buffered result limit.
- `ADDR_W`, 32: memory address width; effective address is truncated to it.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake; transfer on edge where both are 1.
- `opA` in 32, `opB` in 32: base and offset; effective address `ea = opA + opB` (mod 2^32).
- `data` in 32: store data / pass-through value.
- `i` in `instruction_type`: OP0 LB, OP1 LBU, OP2 LH, OP3 LHU, OP4 LW, OP5 SW, OP6 SH, OP7 SB; anything else is non-memory.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_be` out 4, `mem_wdata` out 32: memory request, held stable until grant.
- `mem_gnt` in 1: request accepted by memory.
- `mem_rvalid` in 1, `mem_rdata` in 32: load response, exactly one per granted load, ≥1 cycle after grant.
- `wb_valid` out 1 / `wb_ready` in 1: result handshake.
- `DATA_wb` out 32, `misalign` out 1: FIFO head result and its misalignment flag.

## Operation
- `req_ready = (state==IDLE) && (fifo_count < DEPTH)`.
- FSM: IDLE → REQ (accepted aligned load/store); REQ → WAIT on `mem_gnt` for a load, REQ → IDLE on `mem_gnt` for a store (push `DATA_wb = data`); WAIT → IDLE on `mem_rvalid` (push extended load data).
- Non-memory op or misaligned access: no memory request; stays IDLE; result pushed on the cycle after acceptance (non-memory: `DATA_wb = data`, `misalign=0`; misaligned: `DATA_wb = ea`, `misalign=1`).
- Misaligned: LH/LHU/SH with `ea[0]=1`; LW/SW with `ea[1:0]!=0`.
- Store lanes: SB `mem_be = 4'b0001<<ea[1:0]`, `mem_wdata = {4{data[7:0]}}`; SH `mem_be = 4'b0011<<ea[1:0]`, `mem_wdata = {2{data[15:0]}}`; SW `mem_be = 4'hF`, `mem_wdata = data`. Loads: `mem_be = 4'hF`, `mem_we = 0`.
- Load extract: byte = `mem_rdata[8*ea[1:0] +: 8]`, half = `mem_rdata[16*ea[1] +: 16]`; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- FIFO: push and pop in same cycle allowed at any count, including full; order preserved; `wb_valid = fifo_count != 0`.
- `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.

## Timing
- Reset (async assert, any state): state IDLE, FIFO empty; `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_be=0`, `mem_wdata=0`, `wb_valid=0`, `DATA_wb=0`, `misalign=0`; `req_ready=1` (IDLE, empty FIFO). An in-flight memory transaction is abandoned; a late `mem_rvalid` is discarded.
- `mem_*` outputs are registered: `mem_req` rises the cycle after acceptance.
- Minimum latency acceptance → `wb_valid`: store with same-cycle grant 2 cycles; load with grant at cycle 1 and rvalid at cycle 2 → 3 cycles; non-memory/misaligned 1 cycle.
- Throughput: one memory op in flight; next request accepted the cycle after return to IDLE.
- With `wb_ready=0`, a load still completes into the FIFO (slot reserved by the `req_ready` rule); `mem_rvalid` is never back-pressured.

## Structure
- Package `my_pkg`: `instruction_type` with OP0–OP7, `lsu_state_t` {IDLE, REQ, WAIT}, byte-enable constants.
- Sub-module `lsu_resp_fifo` (parameter `DEPTH`, width 33 = `{misalign, DATA_wb}`, count output, async active-low reset).

## Test plan
- LB, `ea=0x1003`, `mem_rdata=0x80FF_FF00` → `mem_be=4'hF`, `DATA_wb=0xFFFF_FF80`; LBU same → `0x0000_0080`.
- SH, `opA=0x100`, `opB=2`, `data=0x1234_ABCD` → `mem_be=4'b1100`, `mem_wdata=0xABCD_ABCD`, `mem_we=1`; `DATA_wb=0x1234_ABCD`.
- LW `ea=0x102` → no `mem_req`, `misalign=1`, `DATA_wb=0x102` one cycle after acceptance.
- `mem_gnt` held low 5 cycles → `mem_req`, `mem_addr`, `mem_be` stable all 5 cycles; `req_ready=0` throughout.
- `DEPTH=2`, `wb_ready=0`, three back-to-back LW → two results buffered, `req_ready=0` for the third until one pop; results drain in order.
- `reset_n` pulsed low in WAIT, then `mem_rvalid=1` → all outputs at reset values, no FIFO push.

Source files
------------

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types, byte-enable constants and load-extension helper for the load/store unit
package my_pkg;

  typedef enum logic [3:0] {
    OP0 = 4'd0,  // LB
    OP1 = 4'd1,  // LBU
    OP2 = 4'd2,  // LH
    OP3 = 4'd3,  // LHU
    OP4 = 4'd4,  // LW
    OP5 = 4'd5,  // SW
    OP6 = 4'd6,  // SH
    OP7 = 4'd7   // SB
  } instruction_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [31:0] load_extend(input instruction_type op,
                                              input logic [1:0]      ea_lo,
                                              input logic [31:0]     rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{ea_lo, 3'b000} +: 8];
    h = rdata[{ea_lo[1], 4'b0000} +: 16];
    case (op)
      OP0:     load_extend = {{24{b[7]}}, b};
      OP1:     load_extend = {24'd0, b};
      OP2:     load_extend = {{16{h[15]}}, h};
      OP3:     load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// rtl/lsu_resp_fifo.sv - response FIFO; simultaneous push and pop allowed even when full
// Head reads as zero while empty so the write-back outputs idle at zero.
module lsu_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: one memory op in flight, lane steering, load extension, result FIFO
module load_store_unit
  import my_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       opA,
  input  logic [31:0]       opB,
  input  logic [31:0]       data,
  input  instruction_type   i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       DATA_wb,
  output logic              misalign
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  instruction_type   op_q, op_d;
  logic [1:0]        ea_lo_q, ea_lo_d;
  logic [31:0]       data_q, data_d;

  logic [31:0]       ea;
  logic              is_mem, is_store, mis, accept, push;
  logic [32:0]       push_data, head;
  logic [CNT_W-1:0]  fifo_count;

  assign ea        = opA + opB;
  assign is_mem    = (i <= OP7);
  assign is_store  = (i == OP5) || (i == OP6) || (i == OP7);
  assign req_ready = (state_q == IDLE) && (fifo_count < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (i)
      OP2, OP3, OP6: mis = ea[0];
      OP4, OP5:      mis = (ea[1:0] != 2'b00);
      default:       mis = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    op_d        = op_q;
    ea_lo_d     = ea_lo_q;
    data_d      = data_q;
    push        = 1'b0;
    push_data   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && !mis) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = ea[ADDR_W-1:0];
            op_d       = i;
            ea_lo_d    = ea[1:0];
            data_d     = data;
            case (i)
              OP7: begin
                mem_be_d    = BE_BYTE << ea[1:0];
                mem_wdata_d = {4{data[7:0]}};
              end
              OP6: begin
                mem_be_d    = BE_HALF << ea[1:0];
                mem_wdata_d = {2{data[15:0]}};
              end
              OP5: begin
                mem_be_d    = BE_WORD;
                mem_wdata_d = data;
              end
              default: begin
                mem_be_d    = BE_WORD;
                mem_wdata_d = '0;
              end
            endcase
          end else begin
            // Misaligned accesses report the faulting address instead of data.
            push      = 1'b1;
            push_data = mis ? {1'b1, ea} : {1'b0, data};
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          if (mem_we_q) begin
            state_d   = IDLE;
            push      = 1'b1;
            push_data = {1'b0, data_q};
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d   = IDLE;
          push      = 1'b1;
          push_data = {1'b0, load_extend(op_q, ea_lo_q, mem_rdata)};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      op_q        <= OP0;
      ea_lo_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      op_q        <= op_d;
      ea_lo_q     <= ea_lo_d;
      data_q      <= data_d;
    end
  end

  lsu_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (wb_valid && wb_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = (fifo_count != '0);
  assign DATA_wb   = head[31:0];
  assign misalign  = head[32];

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;
  import my_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [31:0]     opA = '0, opB = '0, data = '0;
  instruction_type i = OP0;
  logic            mem_req, mem_we;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic            mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [31:0]     DATA_wb;
  logic            misalign;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    instruction_type op;
    logic [31:0] a, b, d, rdata;
    int          gdel;
    logic        is_mem, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, res;
    logic        mis;
  } vec_t;
  vec_t vecs[12];

  load_store_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .opA(opA), .opB(opB), .data(data), .i(i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .DATA_wb(DATA_wb), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (reset_n && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got %h/%0b, expected no result", DATA_wb, misalign);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("wb_data", DATA_wb, e[31:0]);
        chk("wb_misalign", 32'(misalign), 32'(e[32]));
      end
    end
  end

  task automatic issue(input instruction_type op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    i = op; opA = a; opB = b; data = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got req_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serve(input int gdel, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata);
    for (int k = 0; k <= gdel; k++) begin
      mem_gnt = (k == gdel);
      @(negedge clk);
      chk("mem_req_held", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, addr);
      chk("mem_be", 32'(mem_be), 32'(be));
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (we) chk("mem_wdata", mem_wdata, wdata);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    if (!we) begin
      mem_rdata  = rdata;
      mem_rvalid = 1'b1;
      @(negedge clk);
      chk("mem_req_after_gnt", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_DATA_wb"}, DATA_wb, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    vecs[0]  = '{OP0, 32'h1000, 32'h3, 32'h0, 32'h80FF_FF00, 0, 1'b1, 1'b0, 32'h1003, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{OP1, 32'h1000, 32'h3, 32'h0, 32'h80FF_FF00, 1, 1'b1, 1'b0, 32'h1003, 4'hF, 32'h0, 32'h0000_0080, 1'b0};
    vecs[2]  = '{OP2, 32'h10000, 32'h2, 32'h0, 32'h8001_7FFF, 0, 1'b1, 1'b0, 32'h10002, 4'hF, 32'h0, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{OP3, 32'h10000, 32'h0, 32'h0, 32'h8001_7FFF, 0, 1'b1, 1'b0, 32'h10000, 4'hF, 32'h0, 32'h0000_7FFF, 1'b0};
    vecs[4]  = '{OP4, 32'h20, 32'h4, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{OP6, 32'h100, 32'h2, 32'h1234_ABCD, 32'h0, 0, 1'b1, 1'b1, 32'h102, 4'b1100, 32'hABCD_ABCD, 32'h1234_ABCD, 1'b0};
    vecs[6]  = '{OP7, 32'h200, 32'h1, 32'h0000_0055, 32'h0, 5, 1'b1, 1'b1, 32'h201, 4'b0010, 32'h5555_5555, 32'h0000_0055, 1'b0};
    vecs[7]  = '{OP5, 32'hFFFF_FFF0, 32'h14, 32'h1122_3344, 32'h0, 0, 1'b1, 1'b1, 32'h4, 4'hF, 32'h1122_3344, 32'h1122_3344, 1'b0};
    vecs[8]  = '{OP4, 32'h100, 32'h2, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h102, 1'b1};
    vecs[9]  = '{OP6, 32'h7, 32'h0, 32'hAAAA_BBBB, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h7, 1'b1};
    vecs[10] = '{instruction_type'(4'd9), 32'h5, 32'h6, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{OP5, 32'h0, 32'h2, 32'h1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h2, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      exp_q.push_back({vecs[v].mis, vecs[v].res});
      issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].d);
      if (vecs[v].is_mem) begin
        serve(vecs[v].gdel, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, vecs[v].rdata);
      end else begin
        @(negedge clk);
        chk("nomem_req", 32'(mem_req), 32'd0);
        chk("nomem_wb_valid_1cyc", 32'(wb_valid), 32'd1);
        @(posedge clk); #1;
      end
      drain(20);
    end

    // Back-pressure: two loads fill the FIFO, the third waits for a pop.
    wb_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hA0A0_0001});
    issue(OP4, 32'h300, 32'h0, 32'h0);
    serve(0, 1'b0, 32'h300, 4'hF, 32'h0, 32'hA0A0_0001);
    exp_q.push_back({1'b0, 32'hB0B0_0002});
    issue(OP4, 32'h304, 32'h0, 32'h0);
    serve(1, 1'b0, 32'h304, 4'hF, 32'h0, 32'hB0B0_0002);
    req_valid = 1'b1; i = OP4; opA = 32'h308; opB = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_req_ready", 32'(req_ready), 32'd0);
      chk("full_wb_valid", 32'(wb_valid), 32'd1);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wb_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hC0C0_0003});
    issue(OP4, 32'h308, 32'h0, 32'h0);
    serve(0, 1'b0, 32'h308, 4'hF, 32'h0, 32'hC0C0_0003);
    wb_ready = 1'b1;
    drain(20);

    // Reset while waiting on load data; the buffered result and the late rvalid are both dropped.
    wb_ready = 1'b0;
    issue(instruction_type'(4'd12), 32'h0, 32'h0, 32'h1357_9BDF);
    issue(OP4, 32'h400, 32'h0, 32'h0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("wait_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    wb_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_rvalid_req_ready", 32'(req_ready), 32'd1);

    drain(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
